// File: rtl/word_rx.sv
// word_rx: assembles sync / payload (LSB first) / checksum UART frames into a wide word
//   clk      : rising-edge clock
//   nRst     : synchronous reset, active-high
//   in       : byte strobe, one byte per high cycle
//   data_in  : received byte, valid when in=1
//   word     : last payload whose checksum was good
//   valid    : one-cycle pulse, word has just been updated
//   err      : one-cycle pulse, frame dropped (bad checksum or timeout)
//   busy     : frame in progress
//   count    : payload bytes accepted so far in the current frame
module word_rx #(
    parameter int         BYTES   = 16,
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TIMEOUT = 1000000
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               in,
    input  logic [7:0]         data_in,
    output logic [BYTES*8-1:0] word,
    output logic               valid,
    output logic               err,
    output logic               busy,
    output logic [4:0]         count
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
    state_t             state, state_nx;
    logic [TW-1:0]      tcnt;
    logic [7:0]         sum, total;
    logic [BYTES*8-1:0] shadow;
    logic               take, good, bad, expire;
    assign take  = state == PAYLOAD && in;
    assign total = sum + data_in;
    assign good  = state == CHECK && in && total == 8'd0;
    assign bad   = state == CHECK && in && total != 8'd0;
    // a byte arriving on the expiry cycle wins, so expiry requires in=0
    assign expire = state != IDLE && !in && tcnt == TW'(TIMEOUT - 1);
    assign busy  = state != IDLE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (in && data_in == SYNC) ? PAYLOAD : IDLE;
            PAYLOAD: state_nx = expire ? IDLE : ((take && count == 5'(BYTES - 1)) ? CHECK : PAYLOAD);
            CHECK:   state_nx = (in || expire) ? IDLE : CHECK;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (nRst) begin
            state  <= IDLE;
            tcnt   <= '0;
            sum    <= '0;
            count  <= '0;
            shadow <= '0;
            word   <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            tcnt  <= (state_nx == IDLE || in) ? '0 : tcnt + TW'(1);
            sum   <= (state == IDLE) ? 8'd0 : (take ? total : sum);
            count <= (state_nx == IDLE) ? 5'd0 : (take ? count + 5'd1 : count);
            valid <= good;
            err   <= bad || expire;
            if (good)
                word <= shadow;
            for (int k = 0; k < BYTES; k++)
                if (take && count == 5'(k))
                    shadow[8*k +: 8] <= data_in;
        end
    end
endmodule

// File: tb/tb_word_rx.sv
// tb_word_rx: table-driven and scoreboard bench for word_rx
module tb_word_rx;
    localparam int         BYTES = 16;
    localparam logic [7:0] SYNC  = 8'hA5;
    typedef struct {
        logic [127:0] payload;
        logic [7:0]   cks;
        logic         good;
        logic         noise;
        int           gap_at;
        int           gap_len;
    } vec_t;
    typedef struct {
        logic         good;
        logic [127:0] word;
    } exp_t;
    logic         clk, nRst, in, valid, err, busy;
    logic [7:0]   data_in;
    logic [127:0] word;
    logic [4:0]   count;
    int           total = 0, bad = 0, cyc = 0;
    exp_t         sb[$];
    int           vtimes[$];
    logic [127:0] last_good = '0;
    vec_t         vecs[6];
    word_rx #(.BYTES(BYTES), .SYNC(SYNC), .TIMEOUT(8)) dut (
        .clk(clk), .nRst(nRst), .in(in), .data_in(data_in), .word(word),
        .valid(valid), .err(err), .busy(busy), .count(count)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!nRst && (valid || err)) begin
            check("valid_err_exclusive", valid && err, 1'b0);
            if (valid)
                vtimes.push_back(cyc);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_pulse: got valid=%b err=%b want no pulse", valid, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_valid", valid, e.good);
                check("pulse_err", err, !e.good);
                check("pulse_word", word, e.word);
            end
        end
    end
    function automatic logic [7:0] cks_of(input logic [127:0] p);
        logic [7:0] s;
        s = 8'd0;
        for (int k = 0; k < BYTES; k++)
            s = s + p[8*k +: 8];
        return 8'd0 - s;
    endfunction
    task automatic send_byte(input logic [7:0] b);
        in = 1'b1;
        data_in = b;
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send_frame(input vec_t v);
        exp_t e;
        if (v.noise) begin
            send_byte(8'h3C);
            send_byte(8'hFF);
        end
        send_byte(SYNC);
        for (int k = 0; k <= BYTES; k++) begin
            if (k == v.gap_at)
                idle(v.gap_len);
            if (k == BYTES) begin
                e.good = v.good;
                e.word = v.good ? v.payload : last_good;
                sb.push_back(e);
                if (v.good)
                    last_good = v.payload;
                send_byte(v.cks);
            end else
                send_byte(v.payload[8*k +: 8]);
        end
    endtask
    initial begin
        vec_t  a, b;
        exp_t  e;
        int    n;
        logic [127:0] r;
        vecs[0] = '{128'h0F0E0D0C0B0A09080706050403020100, 8'h88, 1'b1, 1'b0, -1, 0};
        vecs[1] = '{128'h0F0E0D0C0B0A09080706050403020100, 8'h89, 1'b0, 1'b0, -1, 0};
        vecs[2] = '{128'h0F0E0D0C0B0A09080706A50403020100, 8'hE8, 1'b1, 1'b1, -1, 0};
        r = {$urandom, $urandom, $urandom, $urandom};
        vecs[3] = '{r, cks_of(r), 1'b1, 1'b0, 5, 7};
        r = {$urandom, $urandom, $urandom, $urandom};
        vecs[4] = '{r, cks_of(r) ^ 8'h01, 1'b0, 1'b0, 16, 7};
        r = {16{8'hA5}};
        vecs[5] = '{r, cks_of(r), 1'b1, 1'b0, 0, 7};
        nRst = 1'b1;
        in = 1'b0;
        data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        nRst = 1'b0;
        check("reset_word", word, '0);
        check("reset_valid", valid, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_count", count, 5'd0);
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i]);
            idle(2);
            check($sformatf("vec%0d_busy", i), busy, 1'b0);
            check($sformatf("vec%0d_count", i), count, 5'd0);
        end
        send_byte(SYNC);
        check("sync_busy", busy, 1'b1);
        check("sync_count", count, 5'd0);
        for (int k = 0; k < 5; k++)
            send_byte(8'h10 + 8'(k));
        check("partial_count", count, 5'd5);
        e.good = 1'b0;
        e.word = last_good;
        sb.push_back(e);
        in = 1'b0;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (err && n == 0)
                n = i;
        end
        check("timeout_cycles", n, 8);
        check("timeout_count", count, 5'd0);
        check("timeout_busy", busy, 1'b0);
        send_frame(vecs[0]);
        idle(2);
        send_byte(SYNC);
        for (int k = 0; k < 7; k++)
            send_byte(8'h20 + 8'(k));
        in = 1'b0;
        nRst = 1'b1;
        @(posedge clk);
        #1;
        nRst = 1'b0;
        last_good = '0;
        check("midrst_word", word, '0);
        check("midrst_valid", valid, 1'b0);
        check("midrst_err", err, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_count", count, 5'd0);
        idle(1);
        send_frame(vecs[2]);
        idle(2);
        vtimes.delete();
        a = vecs[3];
        a.gap_at = -1;
        r = {$urandom, $urandom, $urandom, $urandom};
        b = '{r, cks_of(r), 1'b1, 1'b0, -1, 0};
        send_frame(a);
        send_frame(b);
        idle(3);
        check("b2b_pulses", vtimes.size(), 2);
        if (vtimes.size() == 2)
            check("b2b_spacing", vtimes[1] - vtimes[0], 18);
        check("b2b_word", word, r);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
